// File: rtl/md_seq_engine_if.sv
// Request/response bundle between the E-stage issue logic and the multiply/divide engine.
interface md_seq_engine_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] numa;
  logic [WIDTH-1:0] numb;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             div_by_zero;

  modport master (
    output start, op, numa, numb, abort,
    input  busy, done, hi_out, lo_out, div_by_zero
  );

  modport slave (
    input  start, op, numa, numb, abort,
    output busy, done, hi_out, lo_out, div_by_zero
  );
endinterface

// File: rtl/md_seq_engine.sv
// Iterative shift-add multiplier / restoring divider producing a {hi,lo} result
// with a one-cycle done pulse; magnitudes are computed and signs re-applied at the end.
module md_seq_engine #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic            clk,
  input  logic            reset,
  md_seq_engine_if.slave  bus
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_count;
  logic             r_is_div, r_neg_q, r_neg_r, r_zero;
  logic [WIDTH-1:0] r_a, r_b, r_rem, r_quo;
  logic             r_busy, r_done, r_dbz;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_load, w_iter, w_finish, w_busy_nxt;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_sum, w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [W2-1:0]    w_prod, w_prod_neg;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; abort flushes any in-flight operation
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_CALC;
      S_CALC: begin
        if (bus.abort)                          w_state_nxt = S_IDLE;
        else if (r_count == CW'(ITER - 1))      w_state_nxt = S_SIGN;
      end
      S_SIGN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM control outputs
  always_comb begin
    w_load     = 1'b0;
    w_iter     = 1'b0;
    w_finish   = 1'b0;
    w_busy_nxt = (w_state_nxt != S_IDLE);
    case (r_state)
      S_IDLE:  w_load   = bus.start;
      S_CALC:  w_iter   = !bus.abort;
      S_SIGN:  w_finish = !bus.abort;
      default: ;
    endcase
  end

  // Operand magnitudes; op[0] selects signed, op[1] selects divide
  assign w_a_neg = bus.op[0] & bus.numa[WIDTH-1];
  assign w_b_neg = bus.op[0] & bus.numb[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~bus.numa + WIDTH'(1)) : bus.numa;
  assign w_b_mag = w_b_neg ? (~bus.numb + WIDTH'(1)) : bus.numb;

  // Multiply step: {r_rem, r_quo} is the running product with the multiplier in the low half
  assign w_sum = {1'b0, r_rem} + (r_quo[0] ? {1'b0, r_a} : '0);

  // Divide step: r_quo shifts dividend bits out of the top and quotient bits in at the bottom
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift[WIDTH-1:0] - r_b;

  assign w_prod     = {r_rem, r_quo};
  assign w_prod_neg = ~w_prod + W2'(1);

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_zero   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_finish;
      if (w_load) begin
        r_is_div <= bus.op[1];
        r_a      <= bus.op[1] ? bus.numa : w_a_mag;
        r_b      <= w_b_mag;
        r_rem    <= '0;
        r_quo    <= bus.op[1] ? w_a_mag : w_b_mag;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_zero   <= (bus.numb == '0);
        r_count  <= '0;
      end
      if (w_iter) begin
        r_count <= r_count + CW'(1);
        if (r_is_div) begin
          r_rem <= w_ge ? w_diff : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
        end else begin
          r_rem <= w_sum[WIDTH:1];
          r_quo <= {w_sum[0], r_quo[WIDTH-1:1]};
        end
      end
      // Divide-by-zero forces hi = original dividend, lo = all ones
      if (w_finish) begin
        r_dbz <= r_is_div & r_zero;
        if (r_is_div && r_zero) begin
          r_hi <= r_a;
          r_lo <= '1;
        end else if (r_is_div) begin
          r_hi <= r_neg_r ? (~r_rem + WIDTH'(1)) : r_rem;
          r_lo <= r_neg_q ? (~r_quo + WIDTH'(1)) : r_quo;
        end else begin
          {r_hi, r_lo} <= r_neg_q ? w_prod_neg : w_prod;
        end
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.hi_out      = r_hi;
  assign bus.lo_out      = r_lo;
  assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_md_seq_engine.sv
// Scoreboard bench for md_seq_engine: directed ops push expected results, a monitor checks each done.
module tb_md_seq_engine;

  logic clk;
  logic reset;

  md_seq_engine_if #(.WIDTH(32)) bus ();

  md_seq_engine #(.WIDTH(32), .ITER(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          id;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pops one expectation
  always @(negedge clk) begin
    if (reset && bus.done) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("op%0d_hi", e.id),  64'(bus.hi_out),      64'(e.hi));
        chk($sformatf("op%0d_lo", e.id),  64'(bus.lo_out),      64'(e.lo));
        chk($sformatf("op%0d_dbz", e.id), 64'(bus.div_by_zero), 64'(e.dbz));
      end
    end
  end

  task automatic expect_res(input int id, input logic [31:0] hi, input logic [31:0] lo, input logic dbz);
    exp_t e;
    e.id = id; e.hi = hi; e.lo = lo; e.dbz = dbz;
    q.push_back(e);
  endtask

  // Called at a negedge; start is sampled on the following posedge (T0)
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.numa  = a;
    bus.numb  = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = ~op;
    bus.numa  = 32'hDEAD_BEEF;
    bus.numb  = 32'h0000_0003;
  endtask

  // Cycle k = sample after the k-th edge counting T0 as 1; returns at the negedge showing done
  task automatic run(input int inj, output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (bus.done) break;
      if (bus.busy) bcnt++;
      if (cyc == inj) begin
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.numa  = 32'h1234_5678;
        bus.numb  = 32'h0000_0009;
      end
      if (cyc >= 60) begin
        tests++;
        fails++;
        $display("FAIL done_timeout: got no done after %0d cycles expected done at 34", cyc);
        break;
      end
    end
  endtask

  task automatic idle_no_done(input string name);
    int dcnt;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk(name, 64'(dcnt), 64'd0);
  endtask

  initial begin
    int cyc, bcnt;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.numa  = '0;
    bus.numb  = '0;
    bus.abort = 1'b0;
    reset     = 1'b1;
    #1 reset  = 1'b0;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    chk("rst_dbz",  64'(bus.div_by_zero), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // mult -3 * 7, latency and busy window
    expect_res(1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    issue(2'b01, 32'hFFFF_FFFD, 32'd7);
    run(0, cyc, bcnt);
    chk("mult_done_cycle", 64'(cyc), 64'd34);
    chk("mult_busy_cycles", 64'(bcnt), 64'd33);
    @(negedge clk);
    chk("busy_low_after", 64'(bus.busy), 64'd0);

    expect_res(2, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(0, cyc, bcnt);

    // divu 100/7 then div -7/2 issued in the done cycle
    @(negedge clk);
    expect_res(3, 32'd2, 32'd14, 1'b0);
    issue(2'b10, 32'd100, 32'd7);
    run(0, cyc, bcnt);
    expect_res(4, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    issue(2'b11, 32'hFFFF_FFF9, 32'd2);
    run(0, cyc, bcnt);
    chk("b2b_done_cycle", 64'(cyc), 64'd34);

    @(negedge clk);
    expect_res(5, 32'd5, 32'hFFFF_FFFF, 1'b1);
    issue(2'b10, 32'd5, 32'd0);
    run(0, cyc, bcnt);
    chk("dbz_done_cycle", 64'(cyc), 64'd34);

    @(negedge clk);
    expect_res(6, 32'd0, 32'h8000_0000, 1'b0);
    issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    run(0, cyc, bcnt);

    // start re-asserted at cycle 5 while busy must be ignored
    @(negedge clk);
    expect_res(7, 32'd0, 32'd42, 1'b0);
    issue(2'b00, 32'd6, 32'd7);
    run(5, cyc, bcnt);
    chk("ignored_start_cycle", 64'(cyc), 64'd34);
    idle_no_done("ignored_start_no_2nd_done");

    // abort at cycle 10
    issue(2'b01, 32'd1000, 32'd1000);
    repeat (9) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy_low", 64'(bus.busy), 64'd0);
    idle_no_done("abort_no_done");
    chk("abort_hilo_kept", {bus.hi_out, bus.lo_out}, {32'd0, 32'd42});

    expect_res(8, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
    issue(2'b11, 32'hFFFF_FF9C, 32'd7);
    run(0, cyc, bcnt);
    chk("post_abort_cycle", 64'(cyc), 64'd34);

    // asynchronous reset mid-CALC
    @(negedge clk);
    issue(2'b00, 32'd9, 32'd9);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_busy", 64'(bus.busy), 64'd0);
    chk("async_rst_done", 64'(bus.done), 64'd0);
    chk("async_rst_hilo", {bus.hi_out, bus.lo_out}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    expect_res(9, 32'd0, 32'd12, 1'b0);
    issue(2'b00, 32'd3, 32'd4);
    run(0, cyc, bcnt);
    @(negedge clk);
    idle_no_done("final_idle");
    chk("scoreboard_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
